// File: rtl/ins_step_sequencer.sv
// ins_step_sequencer
// Instruction fetch and step sequencer. Fetches a 16-bit instruction word
// into IR, then steps Cnt from 1 up to a per-instruction last step. The
// last step is decoded from IR. Load and store instructions stall at step 3
// until memory is ready. HLT parks the block in HALT until reset.
//
// Ports:
//   clk, rst_n  - rising-edge clock, asynchronous active-low reset
//   MemRdy      - memory ready, sampled on rising clk
//   MemData     - fetched instruction word
//   IR          - instruction register
//   InsM / InsL - IR[15:11] / IR[1:0]
//   Cnt         - step counter (0 = fetch)
//   MemReq      - memory access request (combinational)
//   Buff_PC     - last step of the current instruction (combinational)
//   Halted      - block is in HALT
//   IllegalIns  - IR holds an undecodable instruction (combinational)
//
// Configuration macro ILLEGAL_TRAP_EN:
//   defined   - an illegal instruction halts the block at step 1 and keeps
//               IllegalIns asserted until reset
//   undefined - an illegal instruction executes as a one-step NOP
module ins_step_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemRdy,
  input  logic [15:0] MemData,
  output logic [15:0] IR,
  output logic [4:0]  InsM,
  output logic [1:0]  InsL,
  output logic [2:0]  Cnt,
  output logic        MemReq,
  output logic        Buff_PC,
  output logic        Halted,
  output logic        IllegalIns
);

  localparam int unsigned IW      = 16;
  localparam int unsigned CW      = 3;
  localparam int unsigned CNT_MAX = 4;
  localparam int unsigned MEM_CNT = 3;

`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [IW-1:0] ir_q;

  logic [4:0]    ins_m;
  logic [1:0]    ins_l;
  logic [CW-1:0] last;
  logic          is_mem;
  logic          is_hlt;
  logic          is_ill;
  logic          mem_step;
  logic          mem_wait;
  logic          at_last;
  logic          buff_pc_c;

  assign ins_m = ir_q[15:11];
  assign ins_l = ir_q[1:0];

  // Last-step decode from the opcode (IR[15:11]) and, where needed, IR[1:0]
  always_comb begin
    last   = CW'(1);
    is_mem = 1'b0;
    is_hlt = 1'b0;
    is_ill = 1'b0;
    case (ins_m)
      5'b00001, 5'b00010, 5'b01011, 5'b11000,
      5'b11001, 5'b10000, 5'b10011: last = CW'(2);
      5'b00000, 5'b00111, 5'b01000,
      5'b10001, 5'b10010:           last = CW'(3);
      5'b00101: begin
        last   = CW'(3);
        is_mem = 1'b1;
      end
      5'b00110: begin
        if (ins_l == 2'b01) begin
          last = CW'(3);
        end else if (ins_l == 2'b00) begin
          last   = CW'(3);
          is_mem = 1'b1;
        end else begin
          is_ill = 1'b1;
        end
      end
      5'b00011: begin
        last   = CW'(4);
        is_mem = 1'b1;
      end
      5'b00100: begin
        if (ins_l == 2'b00) begin
          last   = CW'(4);
          is_mem = 1'b1;
        end else begin
          is_ill = 1'b1;
        end
      end
      5'b11100: begin
        if (ins_l == 2'b00) begin
          last = CW'(2);
        end else if (ins_l == 2'b01) begin
          is_hlt = 1'b1;
        end else begin
          is_ill = 1'b1;
        end
      end
      default: is_ill = 1'b1;
    endcase
  end

  // Step 3 of a load/store is the memory access step; it stalls on !MemRdy
  assign mem_step = (state_q == S_EXEC) && is_mem && (cnt_q == CW'(MEM_CNT));
  assign mem_wait = mem_step && !MemRdy;
  assign at_last  = (state_q == S_EXEC) && (cnt_q == last);

  // A trapped illegal instruction never completes, so it never raises Buff_PC
  assign buff_pc_c = at_last && !mem_wait && !(TRAP_EN && is_ill);

  // Sequencer: fetch, step through execution, park in HALT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      ir_q    <= '0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (cnt_q != '0) begin
            cnt_q <= '0;
          end else if (MemRdy) begin
            ir_q    <= MemData;
            cnt_q   <= CW'(1);
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          if ((cnt_q == '0) || (cnt_q > CW'(CNT_MAX))) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
          end else if (TRAP_EN && is_ill) begin
            state_q <= S_HALT;
            cnt_q   <= '0;
          end else if (buff_pc_c) begin
            state_q <= is_hlt ? S_HALT : S_FETCH;
            cnt_q   <= '0;
          end else if (mem_wait) begin
            cnt_q <= cnt_q;
          end else if (cnt_q < last) begin
            cnt_q <= cnt_q + CW'(1);
          end else begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
          end
        end
        S_HALT: begin
          cnt_q <= '0;
        end
        default: begin
          state_q <= S_FETCH;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // rst_n gates the combinational strobes so they are quiet during reset
  assign IR         = ir_q;
  assign InsM       = ins_m;
  assign InsL       = ins_l;
  assign Cnt        = cnt_q;
  assign MemReq     = rst_n && ((state_q == S_FETCH) || mem_step);
  assign Buff_PC    = rst_n && buff_pc_c;
  assign Halted     = (state_q == S_HALT);
  assign IllegalIns = rst_n && is_ill && (state_q != S_FETCH);

endmodule

// File: tb/tb_ins_step_sequencer.sv
// Directed bench for ins_step_sequencer: fetch/step timing, memory stalls,
// HLT, illegal instructions (both macro settings) and asynchronous reset.
module tb_ins_step_sequencer;

  logic        clk;
  logic        rst_n;
  logic        MemRdy;
  logic [15:0] MemData;
  logic [15:0] IR;
  logic [4:0]  InsM;
  logic [1:0]  InsL;
  logic [2:0]  Cnt;
  logic        MemReq;
  logic        Buff_PC;
  logic        Halted;
  logic        IllegalIns;

  int pass_cnt;
  int total_cnt;

  ins_step_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .MemRdy    (MemRdy),
    .MemData   (MemData),
    .IR        (IR),
    .InsM      (InsM),
    .InsL      (InsL),
    .Cnt       (Cnt),
    .MemReq    (MemReq),
    .Buff_PC   (Buff_PC),
    .Halted    (Halted),
    .IllegalIns(IllegalIns)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; sample 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [15:0] d);
    MemData = d;
    MemRdy  = 1'b1;
    step();
    MemRdy  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    MemRdy  = 1'b0;
    MemData = 16'h0000;
    #1;
    total_cnt++;
    if ({Cnt, IR, MemReq, Buff_PC, IllegalIns, Halted} !== {3'd0, 16'h0000, 4'b0000})
      $display("FAIL reset_hold: Cnt=%0d IR=%h MemReq=%b Buff_PC=%b Ill=%b Halted=%b", Cnt, IR, MemReq, Buff_PC, IllegalIns, Halted);
    else pass_cnt++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    total_cnt++;
    if ({Cnt, MemReq, Buff_PC} !== {3'd0, 1'b1, 1'b0})
      $display("FAIL reset_release: Cnt=%0d MemReq=%b Buff_PC=%b want 0/1/0", Cnt, MemReq, Buff_PC);
    else pass_cnt++;
    step();
    step();
    total_cnt++;
    if ({Cnt, MemReq} !== {3'd0, 1'b1})
      $display("FAIL fetch_wait: Cnt=%0d MemReq=%b want 0/1", Cnt, MemReq);
    else pass_cnt++;
  endtask

  task automatic test_lhi();
    fetch(16'h0800);
    total_cnt++;
    if ({Cnt, IR, InsM, MemReq, Buff_PC} !== {3'd1, 16'h0800, 5'b00001, 1'b0, 1'b0})
      $display("FAIL lhi_c1: Cnt=%0d IR=%h InsM=%b MemReq=%b Buff_PC=%b", Cnt, IR, InsM, MemReq, Buff_PC);
    else pass_cnt++;
    MemRdy = 1'b1; // ignored outside a memory request
    step();
    total_cnt++;
    if ({Cnt, MemReq, Buff_PC} !== {3'd2, 1'b0, 1'b1})
      $display("FAIL lhi_c2: Cnt=%0d MemReq=%b Buff_PC=%b want 2/0/1", Cnt, MemReq, Buff_PC);
    else pass_cnt++;
    MemRdy = 1'b0;
    step();
    total_cnt++;
    if ({Cnt, MemReq, Buff_PC} !== {3'd0, 1'b1, 1'b0})
      $display("FAIL lhi_done: Cnt=%0d MemReq=%b Buff_PC=%b want 0/1/0", Cnt, MemReq, Buff_PC);
    else pass_cnt++;
  endtask

  task automatic test_ldr_stall();
    fetch(16'h1800);
    step();
    total_cnt++;
    if ({Cnt, MemReq, Buff_PC} !== {3'd2, 1'b0, 1'b0})
      $display("FAIL ldr_c2: Cnt=%0d MemReq=%b Buff_PC=%b want 2/0/0", Cnt, MemReq, Buff_PC);
    else pass_cnt++;
    step();
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if ({Cnt, MemReq, Buff_PC} !== {3'd3, 1'b1, 1'b0})
        $display("FAIL ldr_stall%0d: Cnt=%0d MemReq=%b Buff_PC=%b want 3/1/0", i, Cnt, MemReq, Buff_PC);
      else pass_cnt++;
      if (i < 2) step();
    end
    step(); // the third stalled edge
    total_cnt++;
    if ({Cnt, MemReq} !== {3'd3, 1'b1})
      $display("FAIL ldr_stall_end: Cnt=%0d MemReq=%b want 3/1", Cnt, MemReq);
    else pass_cnt++;
    MemRdy = 1'b1;
    #1;
    total_cnt++;
    if (Buff_PC !== 1'b0)
      $display("FAIL ldr_rdy_c3: Buff_PC=%b want 0", Buff_PC);
    else pass_cnt++;
    step();
    MemRdy = 1'b0;
    total_cnt++;
    if ({Cnt, MemReq, Buff_PC} !== {3'd4, 1'b0, 1'b1})
      $display("FAIL ldr_c4: Cnt=%0d MemReq=%b Buff_PC=%b want 4/0/1", Cnt, MemReq, Buff_PC);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({Cnt, MemReq, Buff_PC} !== {3'd0, 1'b1, 1'b0})
      $display("FAIL ldr_done: Cnt=%0d MemReq=%b Buff_PC=%b want 0/1/0", Cnt, MemReq, Buff_PC);
    else pass_cnt++;
  endtask

  task automatic test_cmp_str();
    fetch(16'h3001);
    step();
    step();
    total_cnt++;
    if ({Cnt, MemReq, Buff_PC, IllegalIns} !== {3'd3, 1'b0, 1'b1, 1'b0})
      $display("FAIL cmp_c3: Cnt=%0d MemReq=%b Buff_PC=%b Ill=%b want 3/0/1/0", Cnt, MemReq, Buff_PC, IllegalIns);
    else pass_cnt++;
    step();
    fetch(16'h3000);
    step();
    step();
    total_cnt++;
    if ({Cnt, MemReq, Buff_PC} !== {3'd3, 1'b1, 1'b0})
      $display("FAIL str_c3_wait: Cnt=%0d MemReq=%b Buff_PC=%b want 3/1/0", Cnt, MemReq, Buff_PC);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({Cnt, MemReq} !== {3'd3, 1'b1})
      $display("FAIL str_hold: Cnt=%0d MemReq=%b want 3/1", Cnt, MemReq);
    else pass_cnt++;
    MemRdy = 1'b1;
    #1;
    total_cnt++;
    if (Buff_PC !== 1'b1)
      $display("FAIL str_rdy: Buff_PC=%b want 1", Buff_PC);
    else pass_cnt++;
    step();
    MemRdy = 1'b0;
    total_cnt++;
    if ({Cnt, MemReq, Buff_PC} !== {3'd0, 1'b1, 1'b0})
      $display("FAIL str_done: Cnt=%0d MemReq=%b Buff_PC=%b want 0/1/0", Cnt, MemReq, Buff_PC);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    fetch(16'h0000);
    step();
    total_cnt++;
    if (Cnt !== 3'd2)
      $display("FAIL add_c2: Cnt=%0d want 2", Cnt);
    else pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({Cnt, IR, MemReq, Buff_PC} !== {3'd0, 16'h0000, 1'b0, 1'b0})
      $display("FAIL async_rst: Cnt=%0d IR=%h MemReq=%b Buff_PC=%b want 0/0000/0/0", Cnt, IR, MemReq, Buff_PC);
    else pass_cnt++;
    rst_n = 1'b1;
    #1;
    total_cnt++;
    if ({Cnt, MemReq} !== {3'd0, 1'b1})
      $display("FAIL async_rel: Cnt=%0d MemReq=%b want 0/1", Cnt, MemReq);
    else pass_cnt++;
    step();
  endtask

  task automatic test_illegal();
    fetch(16'hF800);
`ifdef ILLEGAL_TRAP_EN
    total_cnt++;
    if ({Cnt, IllegalIns, Buff_PC} !== {3'd1, 1'b1, 1'b0})
      $display("FAIL ill_c1: Cnt=%0d Ill=%b Buff_PC=%b want 1/1/0", Cnt, IllegalIns, Buff_PC);
    else pass_cnt++;
    MemRdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total_cnt++;
      if ({Cnt, Halted, IllegalIns, MemReq, Buff_PC} !== {3'd0, 1'b1, 1'b1, 1'b0, 1'b0})
        $display("FAIL ill_trap%0d: Cnt=%0d Halted=%b Ill=%b MemReq=%b Buff_PC=%b", i, Cnt, Halted, IllegalIns, MemReq, Buff_PC);
      else pass_cnt++;
    end
    MemRdy = 1'b0;
    rst_n  = 1'b0;
    #1;
    rst_n  = 1'b1;
    #1;
    total_cnt++;
    if ({Halted, IllegalIns, MemReq} !== {1'b0, 1'b0, 1'b1})
      $display("FAIL ill_rst: Halted=%b Ill=%b MemReq=%b want 0/0/1", Halted, IllegalIns, MemReq);
    else pass_cnt++;
    step();
`else
    total_cnt++;
    if ({Cnt, IllegalIns, Buff_PC} !== {3'd1, 1'b1, 1'b1})
      $display("FAIL ill_c1: Cnt=%0d Ill=%b Buff_PC=%b want 1/1/1", Cnt, IllegalIns, Buff_PC);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({Cnt, IllegalIns, Halted, MemReq} !== {3'd0, 1'b0, 1'b0, 1'b1})
      $display("FAIL ill_nop: Cnt=%0d Ill=%b Halted=%b MemReq=%b want 0/0/0/1", Cnt, IllegalIns, Halted, MemReq);
    else pass_cnt++;
`endif
  endtask

  task automatic test_hlt();
    fetch(16'hE001);
    total_cnt++;
    if ({Cnt, Buff_PC, Halted, IllegalIns} !== {3'd1, 1'b1, 1'b0, 1'b0})
      $display("FAIL hlt_c1: Cnt=%0d Buff_PC=%b Halted=%b Ill=%b want 1/1/0/0", Cnt, Buff_PC, Halted, IllegalIns);
    else pass_cnt++;
    MemRdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total_cnt++;
      if ({Cnt, Halted, MemReq, Buff_PC, IR} !== {3'd0, 1'b1, 1'b0, 1'b0, 16'hE001})
        $display("FAIL hlt_park%0d: Cnt=%0d Halted=%b MemReq=%b Buff_PC=%b IR=%h", i, Cnt, Halted, MemReq, Buff_PC, IR);
      else pass_cnt++;
    end
    MemRdy = 1'b0;
    rst_n  = 1'b0;
    #1;
    total_cnt++;
    if ({Halted, IR, MemReq} !== {1'b0, 16'h0000, 1'b0})
      $display("FAIL hlt_rst: Halted=%b IR=%h MemReq=%b want 0/0000/0", Halted, IR, MemReq);
    else pass_cnt++;
    rst_n = 1'b1;
    step();
    fetch(16'h0800);
    total_cnt++;
    if ({Cnt, IR} !== {3'd1, 16'h0800})
      $display("FAIL hlt_refetch: Cnt=%0d IR=%h want 1/0800", Cnt, IR);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_lhi();
    test_ldr_stall();
    test_cmp_str();
    test_async_reset();
    test_illegal();
    test_hlt();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/ins_step_sequencer.md
INS_STEP_SEQUENCER -- requirements
Module: ins_step_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports: clk input 1 (rising-edge clock); rst_n input 1 (async active-low reset).
REQ-002 The block SHALL have these ports:
- MemRdy input 1: memory ready, sampled on rising clk.
- MemData input 16: fetched instruction word.
- IR output 16: instruction register.
- InsM output 5: equals IR[15:11].
- InsL output 2: equals IR[1:0].
- Cnt output 3: step counter.
- MemReq output 1: memory access request.
- Buff_PC output 1: last step of current instruction.
- Halted output 1: HLT executed.
- IllegalIns output 1: undecodable instruction in IR.

Function
REQ-003 States SHALL be FETCH (Cnt=0), EXEC (Cnt=1..Last) and HALT.
REQ-004 In FETCH, MemReq SHALL be 1 and Cnt SHALL hold 0 while MemRdy=0.
REQ-005 On a clk edge in FETCH with MemRdy=1, the block SHALL load IR from MemData and set Cnt=1 (EXEC).
REQ-006 Last SHALL decode combinationally from IR:
- Last=2: LHI 00001, LLI 00010, MOV 01011, branches 11000/11001, JMP 10000, JR 10011, OutR 11100 with L=00.
- Last=3: ALU 00000 (any L), ADDI 00111, SUBI 01000, CMP 00110 with L=01, STRri 00101, STRrr 00110 with L=00, JALrl 10001, JALrr 10010.
- Last=4: LDRri 00011, LDRrr 00100 with L=00.
REQ-007 HLT (11100 with L=01) SHALL set Last=1.
REQ-008 Any other encoding SHALL be illegal, with Last=1, and IllegalIns SHALL be 1 while Cnt≥1.
REQ-009 In EXEC, Cnt SHALL increment by 1 each clk while Cnt<Last.
REQ-010 MemReq SHALL be 1 at Cnt=3 for LDRri, LDRrr, STRri and STRrr; at that step Cnt SHALL hold until MemRdy=1.
REQ-011 Buff_PC SHALL be 1 combinationally when Cnt=Last in EXEC and no MemReq wait is pending (MemRdy=1 if MemReq=1).
REQ-012 Buff_PC SHALL be 0 in FETCH and HALT.
REQ-013 After a Buff_PC cycle, the next state SHALL be FETCH with Cnt=0, except HLT, which SHALL go to HALT.
REQ-014 In HALT: Cnt=0, MemReq=0, Buff_PC=0, Halted=1, IR held; the block SHALL leave HALT only via rst_n.
REQ-015 Cnt SHALL never exceed 4; any out-of-range Cnt SHALL force FETCH with Cnt=0 on the next edge.
REQ-016 MemRdy=1 outside a MemReq cycle SHALL be ignored.

Reset
REQ-017 rst_n=0 SHALL asynchronously force FETCH with Cnt=0, IR=16'h0000, Halted=0, regardless of current state or any pending memory wait.
REQ-018 While rst_n=0: MemReq=0, Buff_PC=0, IllegalIns=0.
REQ-019 The first fetch SHALL begin on the first clk edge after rst_n rises, with MemReq=1 from deassertion.

Configuration
REQ-020 Macro ILLEGAL_TRAP_EN SHALL control illegal-instruction handling.
- Defined: an illegal instruction SHALL enter HALT at Cnt=1 with Buff_PC=0 and IllegalIns held at 1 until reset.
- Undefined: an illegal instruction SHALL behave as a NOP per REQ-008, with Buff_PC=1 at Cnt=1 and then FETCH.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- V1: reset; MemRdy=1; MemData=16'h0800 (LHI) -> Cnt 0,1,2; Buff_PC=1 at Cnt=2; Cnt=0 next edge.
- V2: MemData=16'h1800 (LDRri); MemRdy=0 for 3 cycles at Cnt=3 -> Cnt holds 3 with MemReq=1; Buff_PC=1 at Cnt=4 only.
- V3: 16'h3001 (CMP) then 16'h3000 (STRrr) -> Last=3 for both; MemReq=1 at Cnt=3 for STRrr only.
- V4: 16'hE001 (HLT) -> Buff_PC=1 at Cnt=1, then Halted=1 and Cnt=0 indefinitely; rst_n pulse -> FETCH.
- V5: 16'hF800 (illegal) -> without ILLEGAL_TRAP_EN: IllegalIns=1 at Cnt=1, Buff_PC=1, then fetch; with it: HALT, IllegalIns sticky.
- V6: rst_n=0 asserted mid-clock at Cnt=2 of ADD -> Cnt=0 and IR=0 immediately, without waiting for clk.
